// File: rtl/gate_truth_checker.sv
// Self-test engine for a 2-input gate: walks the four input vectors, lets each
// settle, samples z and compares against the TRUTH table, then reports results.
module gate_truth_checker #(
   parameter logic [3:0] TRUTH  = 4'b0001,
   parameter int         SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       z,
   output logic       x1,
   output logic       x2,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask,
   output logic [2:0] err_count
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE} state_t;

   localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

   state_t     state;
   logic [7:0] cnt;
   logic [1:0] idx;
   logic       mis;
   logic [3:0] mask_final;

   assign mis        = (z != TRUTH[idx]);
   // pass must reflect the last sample, which is not yet in fail_mask
   assign mask_final = fail_mask | (mis ? (4'b0001 << idx) : 4'b0000);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         idx       <= '0;
         x1        <= 1'b0;
         x2        <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_mask <= '0;
         err_count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  idx       <= '0;
                  {x1, x2}  <= 2'b00;
                  cnt       <= '0;
                  fail_mask <= '0;
                  err_count <= '0;
                  pass      <= 1'b0;
                  busy      <= 1'b1;
                  state     <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               cnt <= cnt + 8'd1;
               if (cnt == CNT_LAST) state <= ST_SAMPLE;
            end
            ST_SAMPLE: begin
               if (mis) begin
                  fail_mask[idx] <= 1'b1;
                  err_count      <= err_count + 3'd1;
               end
               if (idx != 2'd3) begin
                  idx      <= idx + 2'd1;
                  {x1, x2} <= idx + 2'd1;
                  cnt      <= '0;
                  state    <= ST_SETTLE;
               end else begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (mask_final == 4'b0000);
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: a NOR-table instance (SETTLE=2) and an
// AND-table instance (SETTLE=1), each driven by a table-lookup gate model.
module tb_gate_truth_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       sel = 1'b0;
   logic [3:0] tbl_a = 4'b0001;
   logic [3:0] tbl_b = 4'b1000;

   logic       x1_a, x2_a, busy_a, done_a, pass_a, z_a;
   logic [3:0] mask_a;
   logic [2:0] err_a;
   logic       x1_b, x2_b, busy_b, done_b, pass_b, z_b;
   logic [3:0] mask_b;
   logic [2:0] err_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign z_a = tbl_a[{x1_a, x2_a}];
   assign z_b = tbl_b[{x1_b, x2_b}];

   gate_truth_checker dut_a (
      .clk(clk), .rst_n(rst_n), .start(start && !sel), .z(z_a),
      .x1(x1_a), .x2(x2_a), .busy(busy_a), .done(done_a), .pass(pass_a),
      .fail_mask(mask_a), .err_count(err_a)
   );

   gate_truth_checker #(.TRUTH(4'b1000), .SETTLE(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start && sel), .z(z_b),
      .x1(x1_b), .x2(x2_b), .busy(busy_b), .done(done_b), .pass(pass_b),
      .fail_mask(mask_b), .err_count(err_b)
   );

   // observed outputs of whichever instance is under test
   logic [1:0] o_x;
   logic       o_busy, o_done, o_pass;
   logic [3:0] o_mask;
   logic [2:0] o_err;
   assign o_x    = sel ? {x1_b, x2_b} : {x1_a, x2_a};
   assign o_busy = sel ? busy_b : busy_a;
   assign o_done = sel ? done_b : done_a;
   assign o_pass = sel ? pass_b : pass_a;
   assign o_mask = sel ? mask_b : mask_a;
   assign o_err  = sel ? err_b  : err_a;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: vector i mismatches when the gate's value differs from TRUTH[i];
   // each vector lasts SETTLE+1 cycles, four vectors per run.
   task automatic body(input string tag, input int k0, input bit repulse, input bit chain);
      int         s1    = sel ? 2 : 3;
      int         lat   = 4 * s1;
      logic [3:0] truth = sel ? 4'b1000 : 4'b0001;
      logic [3:0] tbl   = sel ? tbl_b : tbl_a;
      logic [3:0] emask = tbl ^ truth;
      for (int k = k0; k <= lat; k++) begin
         if (k < lat) begin
            chk({tag, ".busy"}, 8'(o_busy), 8'd1);
            chk({tag, ".done_early"}, 8'(o_done), 8'd0);
            chk({tag, ".x"}, 8'(o_x), 8'(k / s1));
         end else begin
            chk({tag, ".done"}, 8'(o_done), 8'd1);
            chk({tag, ".busy_end"}, 8'(o_busy), 8'd0);
            chk({tag, ".x_end"}, 8'(o_x), 8'd3);
            chk({tag, ".mask"}, 8'(o_mask), 8'(emask));
            chk({tag, ".err"}, 8'(o_err), 8'($countones(emask)));
            chk({tag, ".pass"}, 8'(o_pass), 8'(emask == 4'b0000));
         end
         if (repulse && k == 5) start = 1'b1;
         if (repulse && k == 6) start = 1'b0;
         if (k < lat) @(negedge clk);
      end
      if (chain) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk({tag, ".chain_busy"}, 8'(o_busy), 8'd1);
         chk({tag, ".chain_done"}, 8'(o_done), 8'd0);
         chk({tag, ".chain_mask"}, 8'(o_mask), 8'd0);
         chk({tag, ".chain_err"}, 8'(o_err), 8'd0);
         chk({tag, ".chain_x"}, 8'(o_x), 8'd0);
      end else begin
         @(negedge clk);
         chk({tag, ".done_pulse"}, 8'(o_done), 8'd0);
         chk({tag, ".idle"}, 8'(o_busy), 8'd0);
         chk({tag, ".hold_mask"}, 8'(o_mask), 8'(emask));
      end
   endtask

   task automatic run(input string tag, input logic [3:0] tbl, input bit repulse, input bit chain);
      if (sel) tbl_b = tbl; else tbl_a = tbl;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      body(tag, 0, repulse, chain);
   endtask

   initial begin
      logic [3:0] t;
      @(negedge clk);
      @(negedge clk);
      chk("rst.busy", 8'(busy_a), 8'd0);
      chk("rst.done", 8'(done_a), 8'd0);
      chk("rst.pass", 8'(pass_a), 8'd0);
      chk("rst.mask", 8'(mask_a), 8'd0);
      chk("rst.err", 8'(err_a), 8'd0);
      chk("rst.x", 8'({x1_a, x2_a}), 8'd0);
      chk("rst.busy_b", 8'(busy_b), 8'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run("nor", 4'b0001, 1'b0, 1'b0);
      run("or", 4'b1110, 1'b0, 1'b0);
      run("stuck0", 4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stuck0.held_mask", 8'(mask_a), 8'b0001);
         chk("stuck0.held_err", 8'(err_a), 8'd1);
         chk("stuck0.held_pass", 8'(pass_a), 8'd0);
      end

      // re-pulse mid-run is ignored; start on the done cycle chains a new run
      run("repulse", 4'b0110, 1'b1, 1'b1);
      tbl_a = 4'b0001;
      @(negedge clk);
      body("chained", 1, 1'b0, 1'b0);

      // reset while vector 2 is applied
      tbl_a = 4'b1110;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("rst_mid.x_pre", 8'({x1_a, x2_a}), 8'd2);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_mid.busy", 8'(busy_a), 8'd0);
      chk("rst_mid.x", 8'({x1_a, x2_a}), 8'd0);
      chk("rst_mid.mask", 8'(mask_a), 8'd0);
      chk("rst_mid.err", 8'(err_a), 8'd0);
      chk("rst_mid.pass", 8'(pass_a), 8'd0);
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         chk("rst_mid.no_done", 8'(done_a), 8'd0);
      end
      run("after_rst", 4'b0001, 1'b0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         t = 4'($urandom_range(0, 15));
         run("rand_a", t, 1'b0, 1'b0);
      end

      sel = 1'b1;
      @(negedge clk);
      run("and", 4'b1000, 1'b0, 1'b0);
      run("and_repulse", 4'b0111, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         t = 4'($urandom_range(0, 15));
         run("rand_b", t, 1'b0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
